updown_ctrl: RTL and testbench
==============================

// Module: updown_ctrl
// PURPOSE
//   Sequencing controller for the up/down counter. Consumes the three debounced
//   single-cycle button pulses (UP, DOWN, RUN/STOP) and drives the displayed count.
//   Supports manual single-step and auto-run modes; auto-run is paced by an
//   internal prescaler. Sits between the button front-end and the display decoder.
// PARAMETERS
//   WIDTH     4           count width in bits
//   MAX       9           largest count value; the count wraps MAX<->0 (MAX < 2**WIDTH)
//   TICK_DIV  50_000_000  CLOCK_50 cycles per auto-run step (1 Hz); must be >= 2
// PORTS
//   CLOCK_50  in   1      system clock, 50 MHz
//   RESET     in   1      synchronous reset, active-high
//   BTN       in   3      debounced pulses, each high for 1 cycle: [0]=UP [1]=DOWN [2]=RUN
//   COUNT     out  WIDTH  current count value, registered
//   DIR       out  1      1 = up, 0 = down; direction used by auto-run
//   RUNNING   out  1      1 while in RUN state
//   CARRY     out  1      1-cycle pulse on an up-wrap from MAX to 0
//   BORROW    out  1      1-cycle pulse on a down-wrap from 0 to MAX
// BEHAVIOUR
//   Reset: every register is synchronous on RESET=1 at the CLOCK_50 edge.
//     COUNT=0, DIR=1, RUNNING=0, CARRY=0, BORROW=0, state=STOP, prescaler=0.
//     RESET overrides all BTN inputs in the same cycle. Reset while RUN returns to STOP.
//   States: STOP, RUN. RUNNING is high exactly when the state is RUN.
//   STOP:
//     BTN[2]             -> RUN; clear the prescaler; COUNT unchanged.
//     BTN[0] only        -> COUNT steps +1; DIR<=1.
//     BTN[1] only        -> COUNT steps -1; DIR<=0.
//     BTN[0]&BTN[1]      -> ignored; no step and no DIR change.
//     BTN[2] wins over UP/DOWN in the same cycle, and no step occurs.
//   RUN:
//     tick = (prescaler == TICK_DIV-1). The prescaler wraps to 0 on tick.
//     BTN[2]             -> STOP. Any tick in the same cycle is discarded (no step).
//     BTN[0] / BTN[1]    -> DIR<=1 / DIR<=0. No immediate step.
//       If tick occurs in the same cycle, the step uses the NEW direction.
//       BTN[0]&BTN[1] together leave DIR unchanged.
//     tick, no BTN[2]    -> COUNT steps in DIR.
//   Latency: the first auto step occurs exactly TICK_DIV cycles after the cycle
//     in which BTN[2] is sampled. A manual step is visible on COUNT 1 cycle after
//     the pulse. CARRY and BORROW are asserted in the same cycle that COUNT shows
//     the wrapped value.
//   Step arithmetic:
//     +1 at MAX -> 0 with CARRY=1. -1 at 0 -> MAX with BORROW=1.
//     Otherwise +/-1 modulo nothing. COUNT never exceeds MAX.
//   CARRY and BORROW are 0 in every cycle without a wrap. They are never both 1.
//   The prescaler runs only in RUN; it is held at 0 in STOP.
// STRUCTURE
//   Package updown_pkg:
//     state encoding (STOP=1'b0, RUN=1'b1);
//     BTN bit-index constants (BTN_UP=0, BTN_DN=1, BTN_RUN=2).
//   Sub-module tick_gen #(TICK_DIV):
//     inputs CLOCK_50, RESET, clr, en; output tick (1-cycle pulse).
//     Holds 0 when clr=1 or en=0.
//     Counter width is $clog2(TICK_DIV).
//   Top level:
//     FSM + step decode (combinational next_dir / step_up / step_dn);
//     COUNT/flag registers.
// TESTING  (bench uses WIDTH=4, MAX=9, TICK_DIV=4)
//   1. Assert RESET for 2 cycles with BTN=3'b111
//        -> COUNT=0, DIR=1, RUNNING=0, CARRY=0, BORROW=0.
//   2. STOP, COUNT=9, pulse BTN[0]
//        -> next cycle COUNT=0, CARRY=1 for 1 cycle.
//      Then pulse BTN[1]
//        -> COUNT=9, BORROW=1, DIR=0.
//   3. STOP, COUNT=3, DIR=1, pulse BTN[2] at cycle t
//        -> RUNNING=1; COUNT=4 at t+4, 5 at t+8, 6 at t+12.
//   4. RUN, pulse BTN[1] in the same cycle as a tick at COUNT=6
//        -> COUNT=5, DIR=0; next tick gives COUNT=4.
//   5. RUN, pulse BTN[2] coincident with a tick
//        -> RUNNING=0, COUNT unchanged.
//      Then BTN=3'b011
//        -> no change.
//   6. RUN mid-interval, assert RESET 1 cycle
//        -> STOP, COUNT=0.
//      No step occurs TICK_DIV cycles later.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter controller: FSM states and button bit positions.
package updown_pkg;

  localparam logic [0:0] STOP = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int BTN_UP  = 0;
  localparam int BTN_DN  = 1;
  localparam int BTN_RUN = 2;

endpackage

// File: rtl/updown_ctrl_tick_gen.sv
// Auto-run prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RESET || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/updown_ctrl.sv
// Up/down counter sequencer: manual single-step in STOP, prescaler-paced stepping in RUN,
// with one-cycle CARRY/BORROW pulses on wrap.
module updown_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 9,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [2:0]       BTN,
  output logic [WIDTH-1:0] COUNT,
  output logic             DIR,
  output logic             RUNNING,
  output logic             CARRY,
  output logic             BORROW
);

  localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX);

  logic [0:0] state_q;
  logic [0:0] next_state;
  logic       next_dir;
  logic       step_up;
  logic       step_dn;
  logic       tick;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_run;

  assign btn_up  = BTN[BTN_UP];
  assign btn_dn  = BTN[BTN_DN];
  assign btn_run = BTN[BTN_RUN];

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clr      (btn_run),
    .en       (state_q == RUN),
    .tick     (tick)
  );

  // RUN/STOP toggles take priority; a tick coinciding with a direction change uses the new DIR.
  always_comb begin
    next_state = state_q;
    next_dir   = DIR;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    if (btn_run) begin
      next_state = (state_q == STOP) ? RUN : STOP;
    end else begin
      if (btn_up && !btn_dn) begin
        next_dir = 1'b1;
      end else if (btn_dn && !btn_up) begin
        next_dir = 1'b0;
      end
      if (state_q == STOP) begin
        step_up = btn_up && !btn_dn;
        step_dn = btn_dn && !btn_up;
      end else if (tick) begin
        step_up = next_dir;
        step_dn = !next_dir;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= STOP;
      COUNT   <= '0;
      DIR     <= 1'b1;
      CARRY   <= 1'b0;
      BORROW  <= 1'b0;
    end else begin
      state_q <= next_state;
      DIR     <= next_dir;
      CARRY   <= 1'b0;
      BORROW  <= 1'b0;
      if (step_up) begin
        if (COUNT == CMAX) begin
          COUNT <= '0;
          CARRY <= 1'b1;
        end else begin
          COUNT <= COUNT + 1'b1;
        end
      end else if (step_dn) begin
        if (COUNT == '0) begin
          COUNT  <= CMAX;
          BORROW <= 1'b1;
        end else begin
          COUNT <= COUNT - 1'b1;
        end
      end
    end
  end

  assign RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_updown_ctrl.sv
// Directed bench for updown_ctrl (WIDTH=4, MAX=9, TICK_DIV=4) with an expected-value queue.
module tb_updown_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic [2:0] BTN      = 3'b000;
  logic [3:0] COUNT;
  logic       DIR;
  logic       RUNNING;
  logic       CARRY;
  logic       BORROW;

  int vectors = 0;
  int errs    = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  updown_ctrl #(
    .WIDTH    (4),
    .MAX      (9),
    .TICK_DIV (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .BTN      (BTN),
    .COUNT    (COUNT),
    .DIR      (DIR),
    .RUNNING  (RUNNING),
    .CARRY    (CARRY),
    .BORROW   (BORROW)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] pk(input int c, input bit d, input bit r, input bit ca, input bit bo);
    logic [3:0] c4;
    c4 = 4'(c);
    return {c4, d, r, ca, bo};
  endfunction

  // Drive one cycle of inputs, queue what must appear after the edge, then check it.
  task automatic cyc(input string tag, input bit rst, input logic [2:0] b, input logic [7:0] e);
    exp_t x;
    exp_t got;
    logic [7:0] obs;
    @(negedge CLOCK_50);
    RESET = rst;
    BTN   = b;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
    @(posedge CLOCK_50);
    #1;
    got = sb.pop_front();
    obs = {COUNT, DIR, RUNNING, CARRY, BORROW};
    vectors++;
    assert (obs === got.v) else begin
      errs++;
      $error("FAIL %s: observed cnt=%0d dir=%b run=%b cy=%b bo=%b, expected cnt=%0d dir=%b run=%b cy=%b bo=%b",
             got.tag, obs[7:4], obs[3], obs[2], obs[1], obs[0],
             got.v[7:4], got.v[3], got.v[2], got.v[1], got.v[0]);
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 3'b000, e);
  endtask

  initial begin
    // reset with all buttons held
    cyc("reset0", 1'b1, 3'b111, pk(0, 1, 0, 0, 0));
    cyc("reset1", 1'b1, 3'b111, pk(0, 1, 0, 0, 0));
    idle("post_reset", 1, pk(0, 1, 0, 0, 0));

    // manual wraps in STOP
    cyc("stop_dn_wrap", 1'b0, 3'b010, pk(9, 0, 0, 0, 1));
    idle("borrow_clear", 1, pk(9, 0, 0, 0, 0));
    cyc("stop_up_wrap", 1'b0, 3'b001, pk(0, 1, 0, 1, 0));
    idle("carry_clear", 1, pk(0, 1, 0, 0, 0));
    cyc("stop_dn_wrap2", 1'b0, 3'b010, pk(9, 0, 0, 0, 1));
    cyc("stop_both", 1'b0, 3'b011, pk(9, 0, 0, 0, 0));

    // walk up to 3
    cyc("up_to0", 1'b0, 3'b001, pk(0, 1, 0, 1, 0));
    cyc("up_to1", 1'b0, 3'b001, pk(1, 1, 0, 0, 0));
    cyc("up_to2", 1'b0, 3'b001, pk(2, 1, 0, 0, 0));
    cyc("up_to3", 1'b0, 3'b001, pk(3, 1, 0, 0, 0));

    // RUN wins over UP in the same cycle; auto steps every 4 cycles
    cyc("run_enter", 1'b0, 3'b101, pk(3, 1, 1, 0, 0));
    idle("run_wait1", 3, pk(3, 1, 1, 0, 0));
    idle("run_step4", 1, pk(4, 1, 1, 0, 0));
    idle("run_wait2", 3, pk(4, 1, 1, 0, 0));
    idle("run_step5", 1, pk(5, 1, 1, 0, 0));
    idle("run_wait3", 3, pk(5, 1, 1, 0, 0));
    idle("run_step6", 1, pk(6, 1, 1, 0, 0));
    idle("run_wait4", 3, pk(6, 1, 1, 0, 0));

    // DOWN coincident with tick: step uses new direction
    cyc("run_dn_tick", 1'b0, 3'b010, pk(5, 0, 1, 0, 0));
    cyc("run_both_keep", 1'b0, 3'b011, pk(5, 0, 1, 0, 0));
    idle("run_wait5", 2, pk(5, 0, 1, 0, 0));
    idle("run_step4dn", 1, pk(4, 0, 1, 0, 0));
    idle("run_wait6", 3, pk(4, 0, 1, 0, 0));

    // STOP coincident with tick discards the step
    cyc("stop_on_tick", 1'b0, 3'b100, pk(4, 0, 0, 0, 0));
    cyc("stop_both2", 1'b0, 3'b011, pk(4, 0, 0, 0, 0));
    idle("stop_hold", 5, pk(4, 0, 0, 0, 0));

    // reset mid-interval in RUN
    cyc("run_again", 1'b0, 3'b100, pk(4, 0, 1, 0, 0));
    idle("run_mid", 2, pk(4, 0, 1, 0, 0));
    cyc("reset_in_run", 1'b1, 3'b000, pk(0, 1, 0, 0, 0));
    RESET = 1'b0;
    idle("after_reset", 6, pk(0, 1, 0, 0, 0));

    @(negedge CLOCK_50);
    BTN = 3'b000;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
